// File: rtl/sensor_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sensor_link_pkg
// Description : Framing constants and serializer state type shared by the
//               sensor link transmitter and the anomaly-detection receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package sensor_link_pkg;

    // Line level while no frame is in flight, and the level of the start bit.
    localparam logic SENSOR_IDLE_LEVEL  = 1'b1;
    localparam logic SENSOR_START_LEVEL = 1'b0;

    // Sample width used when an instantiation does not override it.
    localparam int   DEFAULT_DATA_WIDTH = 8;

    // Serializer frame phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Show-ahead FIFO for parallel sensor samples. The head entry
//               is visible combinationally; pointers carry one extra wrap bit
//               so full and empty are told apart without a separate flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [DATA_WIDTH-1:0]        i_data,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [PW-1:0]         w_diff;

    // Requests are qualified here so a push into a full FIFO or a pop from an
    // empty one never moves a pointer.
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    assign w_diff  = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_count = CW'(w_diff);
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset flushes the queue by equalising both pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en && !reset) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sensor_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sensor_serializer
// Description : Accepts parallel samples over valid/ready, queues them, and
//               drives each one onto the single-bit sensor line as a frame of
//               start bit, data MSB-first, stop bit. Every bit is held for
//               CLKS_PER_BIT clocks; queued samples follow back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_serializer
    import sensor_link_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         sensor_data,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [15:0]                  frames_sent
);

    // Hold counter spans 0..CLKS_PER_BIT-1; with one clock per bit it never
    // leaves zero and every phase lasts a single cycle.
    localparam int HCW = $clog2(CLKS_PER_BIT + 1);
    localparam int BIW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [HCW-1:0] c_HOLD_LAST = HCW'(CLKS_PER_BIT - 1);
    localparam logic [BIW-1:0] c_BIT_MSB   = BIW'(DATA_WIDTH - 1);

    ser_state_t              r_state;
    ser_state_t              w_state_nxt;

    logic [HCW-1:0]          r_hold;
    logic [BIW-1:0]          r_bit;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_line;
    logic                    r_busy;
    logic [15:0]             r_frames_sent;

    logic                    w_bit_end;
    logic                    w_pop;
    logic                    w_enter_data;
    logic                    w_next_bit;
    logic                    w_frame_done;
    logic                    w_line_nxt;
    logic                    w_busy_nxt;

    logic [DATA_WIDTH-1:0]   w_fifo_head;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    // ------------------------------------------------------------------------
    // Sample queue. Ready depends only on fullness, never on a same-cycle pop.
    // ------------------------------------------------------------------------
    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_data  (in_data),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (fifo_count)
    );

    assign in_ready    = !w_fifo_full;
    assign sensor_data = r_line;
    assign busy        = r_busy;
    assign frames_sent = r_frames_sent;

    // Last clock of the current bit period.
    assign w_bit_end = (r_hold == c_HOLD_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: phases advance only at the end of a bit period, and
    // a finished stop bit chains straight into the next start bit if queued.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!w_fifo_empty)           w_state_nxt = START;
            START:   if (w_bit_end)               w_state_nxt = DATA;
            DATA:    if (w_bit_end && r_bit == '0) w_state_nxt = STOP;
            STOP:    if (w_bit_end)               w_state_nxt = w_fifo_empty ? IDLE : START;
            default:                              w_state_nxt = IDLE;
        endcase
    end

    // Output/control decode: next line level, busy, FIFO pop and datapath
    // strobes. The line is registered, so each level is chosen one cycle
    // ahead of the phase it belongs to.
    always_comb begin
        w_pop        = 1'b0;
        w_enter_data = 1'b0;
        w_next_bit   = 1'b0;
        w_frame_done = 1'b0;
        w_line_nxt   = r_line;
        w_busy_nxt   = r_busy;
        case (r_state)
            IDLE: begin
                w_line_nxt = SENSOR_IDLE_LEVEL;
                w_busy_nxt = 1'b0;
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_line_nxt = SENSOR_START_LEVEL;
                    w_busy_nxt = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_enter_data = 1'b1;
                    w_line_nxt   = r_shift[DATA_WIDTH-1];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit == '0) begin
                        w_line_nxt = SENSOR_IDLE_LEVEL;
                    end else begin
                        w_next_bit = 1'b1;
                        w_line_nxt = r_shift[DATA_WIDTH-2];
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_frame_done = 1'b1;
                    if (!w_fifo_empty) begin
                        w_pop      = 1'b1;
                        w_line_nxt = SENSOR_START_LEVEL;
                    end else begin
                        w_line_nxt = SENSOR_IDLE_LEVEL;
                        w_busy_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_line_nxt = SENSOR_IDLE_LEVEL;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Bit-hold counter: restarts at every bit boundary and stays cleared
    // while idle so a new frame always gets a full-length start bit.
    always_ff @(posedge clk) begin
        if (reset || r_state == IDLE || w_bit_end) begin
            r_hold <= '0;
        end else begin
            r_hold <= r_hold + HCW'(1);
        end
    end

    // Shift register and bit index: load on pop, shift left per data bit so
    // the next bit to send always sits just below the MSB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_bit   <= '0;
        end else begin
            if (w_pop) begin
                r_shift <= w_fifo_head;
            end else if (w_next_bit) begin
                r_shift <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end
            if (w_enter_data) begin
                r_bit <= c_BIT_MSB;
            end else if (w_next_bit) begin
                r_bit <= r_bit - BIW'(1);
            end
        end
    end

    // Registered line and busy outputs; reset returns the line to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= SENSOR_IDLE_LEVEL;
            r_busy <= 1'b0;
        end else begin
            r_line <= w_line_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Completed-frame counter; wraps silently at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frames_sent <= '0;
        end else if (w_frame_done) begin
            r_frames_sent <= r_frames_sent + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: doc/sensor_serializer.md
# sensor_serializer

Sensor-side transmitter for the single-bit `sensor_data` line consumed by the anomaly-detection front end. It accepts parallel samples over a valid/ready handshake and buffers them in a small FIFO. Each sample is emitted as a framed serial word: start bit, data MSB-first, stop bit. Used as the on-chip sensor model in system benches and as the link driver when samples originate in parallel logic.

## Interface
- `DATA_WIDTH`, 8: sample width in bits.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CLKS_PER_BIT`, 1: clock cycles each serial bit is held; ≥1.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `in_data`  in  DATA_WIDTH  sample to transmit.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept; `!full`, combinational from FIFO state.
- `sensor_data`  out  1  serial line, registered; idle high.
- `busy`  out  1  registered; high while a frame is on the line.
- `fifo_count`  out  $clog2(DEPTH+1)  entries currently queued.
- `frames_sent`  out  16  completed frames, wraps 0xFFFF→0x0000.

## Operation
- Push: `in_valid && in_ready` at an edge writes `in_data` to the FIFO tail. If `in_valid` is asserted while full, no write occurs and the sample is held by the source. There is no pass-through when full: `in_ready` depends only on `full`, even in a cycle where a pop occurs.
- FIFO: show-ahead, with head data available combinationally. Push and pop in the same cycle leave `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `sensor_data`=1, `busy`=0. When the FIFO is non-empty, pop the head into the shift register, drive `sensor_data`=0 and `busy`=1, and go to START.
  - START: hold for CLKS_PER_BIT cycles, then drive data bit DATA_WIDTH-1 and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles. A bit index counts DATA_WIDTH-1 down to 0. After bit 0 completes, drive `sensor_data`=1 and go to STOP.
  - STOP: hold CLKS_PER_BIT cycles. At stop completion, increment `frames_sent`. Then:
    - if the FIFO is non-empty: pop, drive 0, go to START (no idle gap);
    - otherwise: go to IDLE with `busy`=0.
- Frame length: (DATA_WIDTH+2)·CLKS_PER_BIT cycles.
- Bit-hold counter width: $clog2(CLKS_PER_BIT+1). With CLKS_PER_BIT=1 the counter is constant and each state lasts one cycle.

## Timing
- Reset values:
  - `sensor_data`=1, `busy`=0, `fifo_count`=0, `frames_sent`=0;
  - `in_ready`=1 (FIFO empty);
  - FSM in IDLE; FIFO pointers cleared.
- Latency: a sample pushed into an empty FIFO with the FSM in IDLE at edge E0 produces the start bit on `sensor_data` from edge E1.
- Pop happens at the edge that enters START. `fifo_count` drops at that same edge, and `in_ready` rises in the following cycle if the FIFO was full.
- Back-to-back frames: the stop bit of frame N is immediately followed by the start bit of frame N+1 when queued.
- Reset mid-frame: the frame is aborted and the FIFO flushed. The line is high from the edge after reset is sampled. No partial-frame completion and no `frames_sent` increment.
- `in_valid` high during reset: ignored; nothing is written.
- `frames_sent` wrap: the increment from 0xFFFF gives 0x0000, with no flag.

## Structure
- Shared package `sensor_link_pkg`:
  - `SENSOR_IDLE_LEVEL`=1'b1, `SENSOR_START_LEVEL`=1'b0;
  - FSM state enum `ser_state_t` {IDLE, START, DATA, STOP};
  - default DATA_WIDTH.
  - The receiving side uses the same package so framing constants stay in one place.
- Sub-module `sample_fifo` (parameters DATA_WIDTH, DEPTH):
  - ports: push, pop, data in/out, full, empty, count;
  - pointer width $clog2(DEPTH)+1, with the wrap bit distinguishing full from empty.
- Top contains the FSM, shift register, bit counter, hold counter and frame counter.

## Test plan
- Single frame, CLKS_PER_BIT=1, push 0xA5 → `sensor_data` after E1 is 0,1,0,1,0,0,1,0,1,1; `busy` is high for 10 cycles; `frames_sent`=1.
- CLKS_PER_BIT=3, push 0x81 → each bit is held exactly 3 cycles; frame length 30 cycles; start bit begins one cycle after the push.
- Backpressure, DEPTH=4, `in_valid` held high with 0x01..0x06:
  - `in_ready` falls after 4 queued entries;
  - 0x06 waits until a pop frees space;
  - all six frames are output in order, back-to-back with no idle bit between stop and start.
- Reset asserted in the middle of the data bits of 0xFF with 2 samples queued → `sensor_data`=1, `busy`=0, `fifo_count`=0, `frames_sent`=0 the next cycle; no further frames.
- Counter wrap: preload/force, or send 65536 frames → `frames_sent` reads 0x0000 after the 65536th stop bit.
- Simultaneous push/pop with `fifo_count`=2 at a frame boundary → count stays 2; push accepted; order preserved.
